// File: rtl/prf_write_arbiter.sv
// prf_write_arbiter
//   Collects writeback results from PRF_WR_COUNT functional-unit requestors
//   and steers them into PRF_BANK_COUNT single-write-port register-file banks.
//   Each requestor owns a one-entry buffer. A bank is selected by the low PR
//   bits, and each bank picks one buffered entry per cycle round-robin. The
//   winning writes are registered onto the bank write ports. The same writes
//   are broadcast on the writeback bus, which the issue queues use for wakeup.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   wr_req_valid    per requestor: a result is offered this cycle
//   wr_req_PR       per requestor: destination physical register
//   wr_req_data     per requestor: result data
//   wr_req_ready    per requestor: buffer can take a result this cycle
//   bank_wr_valid   per bank: write enable (registered)
//   bank_wr_index   per bank: row within the bank (PR without bank bits)
//   bank_wr_data    per bank: write data
//   wb_bus_valid    per bank: wakeup broadcast valid (same as bank_wr_valid)
//   wb_bus_PR       per bank: full PR being written
module prf_write_arbiter #(
  parameter int XLEN           = 32,
  parameter int PR_COUNT       = 128,
  parameter int PRF_BANK_COUNT = 4,
  parameter int PRF_WR_COUNT   = 7,
  localparam int LOG_PR_COUNT       = $clog2(PR_COUNT),
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
  localparam int INDEX_W            = LOG_PR_COUNT - LOG_PRF_BANK_COUNT
) (
  input  logic                                         CLK,
  input  logic                                         RST,
  input  logic [PRF_WR_COUNT-1:0]                      wr_req_valid,
  input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]    wr_req_PR,
  input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]            wr_req_data,
  output logic [PRF_WR_COUNT-1:0]                      wr_req_ready,
  output logic [PRF_BANK_COUNT-1:0]                    bank_wr_valid,
  output logic [PRF_BANK_COUNT-1:0][INDEX_W-1:0]       bank_wr_index,
  output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]          bank_wr_data,
  output logic [PRF_BANK_COUNT-1:0]                    wb_bus_valid,
  output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]  wb_bus_PR
);

  localparam int WR_IDX_W = (PRF_WR_COUNT > 1) ? $clog2(PRF_WR_COUNT) : 1;

  logic [PRF_WR_COUNT-1:0]                    buf_valid;
  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]  buf_pr;
  logic [PRF_WR_COUNT-1:0][XLEN-1:0]          buf_data;
  logic [PRF_WR_COUNT-1:0]                    buf_grant;

  logic [PRF_BANK_COUNT-1:0][WR_IDX_W-1:0]    rr_ptr;
  logic [PRF_BANK_COUNT-1:0]                  bank_grant_valid;
  logic [PRF_BANK_COUNT-1:0][WR_IDX_W-1:0]    bank_grant_idx;

  // Requestor index base+offset, wrapped at PRF_WR_COUNT (offset < PRF_WR_COUNT).
  function automatic logic [WR_IDX_W-1:0] wrap_idx(input logic [WR_IDX_W-1:0] base,
                                                   input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= PRF_WR_COUNT) sum = sum - PRF_WR_COUNT;
    return WR_IDX_W'(sum);
  endfunction

  // Per-bank round-robin search: walk requestors starting at rr_ptr[b] and
  // grant the first buffered entry whose low PR bits select this bank. Each
  // entry targets exactly one bank, so no requestor can collect two grants.
  always_comb begin
    buf_grant        = '0;
    bank_grant_valid = '0;
    bank_grant_idx   = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int k = 0; k < PRF_WR_COUNT; k++) begin
        if (!bank_grant_valid[b] &&
            buf_valid[wrap_idx(rr_ptr[b], k)] &&
            buf_pr[wrap_idx(rr_ptr[b], k)][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b)) begin
          bank_grant_valid[b]               = 1'b1;
          bank_grant_idx[b]                 = wrap_idx(rr_ptr[b], k);
          buf_grant[wrap_idx(rr_ptr[b], k)] = 1'b1;
        end
      end
    end
  end

  // A buffer can refill in the same cycle it drains.
  assign wr_req_ready = ~buf_valid | buf_grant;

  // Buffer load/drain. A PR 0 result is accepted but discarded. Accepting it
  // still empties the buffer, because ready was only high if the old entry
  // was absent or draining.
  always_ff @(posedge CLK) begin
    if (RST) begin
      buf_valid <= '0;
      buf_pr    <= '0;
      buf_data  <= '0;
    end else begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        if (wr_req_valid[i] && wr_req_ready[i]) begin
          if (wr_req_PR[i] != '0) begin
            buf_valid[i] <= 1'b1;
            buf_pr[i]    <= wr_req_PR[i];
            buf_data[i]  <= wr_req_data[i];
          end else begin
            buf_valid[i] <= 1'b0;
          end
        end else if (buf_grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Register the winning entry of each bank onto its write port and the
  // wakeup bus, and move that bank's pointer just past the winner. Payload
  // registers hold their last value while valid is low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr        <= '0;
      bank_wr_valid <= '0;
      bank_wr_index <= '0;
      bank_wr_data  <= '0;
      wb_bus_PR     <= '0;
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        bank_wr_valid[b] <= bank_grant_valid[b];
        if (bank_grant_valid[b]) begin
          rr_ptr[b]        <= wrap_idx(bank_grant_idx[b], 1);
          bank_wr_index[b] <= buf_pr[bank_grant_idx[b]][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
          bank_wr_data[b]  <= buf_data[bank_grant_idx[b]];
          wb_bus_PR[b]     <= buf_pr[bank_grant_idx[b]];
        end
      end
    end
  end

  assign wb_bus_valid = bank_wr_valid;

endmodule

// File: tb/tb_prf_write_arbiter.sv
// tb_prf_write_arbiter
//   Drives directed and random writeback traffic into prf_write_arbiter.
//   Every cycle it compares ready and the registered bank/wakeup outputs
//   against a cycle-level reference model of the buffering and round-robin
//   rules.
module tb_prf_write_arbiter;

  localparam int XLEN  = 32;
  localparam int NPR   = 128;
  localparam int NB    = 4;
  localparam int NW    = 7;
  localparam int LPR   = 7;
  localparam int IDXW  = 5;

  logic                          CLK;
  logic                          RST;
  logic [NW-1:0]                 wr_req_valid;
  logic [NW-1:0][LPR-1:0]        wr_req_PR;
  logic [NW-1:0][XLEN-1:0]       wr_req_data;
  logic [NW-1:0]                 wr_req_ready;
  logic [NB-1:0]                 bank_wr_valid;
  logic [NB-1:0][IDXW-1:0]       bank_wr_index;
  logic [NB-1:0][XLEN-1:0]       bank_wr_data;
  logic [NB-1:0]                 wb_bus_valid;
  logic [NB-1:0][LPR-1:0]        wb_bus_PR;

  int vector_count;
  int miscompare_count;

  // Reference model state: one slot per requestor, one pointer per bank,
  // and the expected registered outputs.
  bit          m_bv   [NW];
  int          m_pr   [NW];
  int unsigned m_data [NW];
  int          m_ptr  [NB];
  bit          m_ov   [NB];
  int          m_opr  [NB];
  int unsigned m_odata[NB];
  bit          m_ready[NW];
  int          m_win  [NB];

  prf_write_arbiter #(
    .XLEN(XLEN), .PR_COUNT(NPR), .PRF_BANK_COUNT(NB), .PRF_WR_COUNT(NW)
  ) dut (
    .CLK(CLK), .RST(RST),
    .wr_req_valid(wr_req_valid), .wr_req_PR(wr_req_PR), .wr_req_data(wr_req_data),
    .wr_req_ready(wr_req_ready),
    .bank_wr_valid(bank_wr_valid), .bank_wr_index(bank_wr_index),
    .bank_wr_data(bank_wr_data), .wb_bus_valid(wb_bus_valid), .wb_bus_PR(wb_bus_PR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vector_count++;
    if (actual !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NW; i++) begin m_bv[i] = 0; m_pr[i] = 0; m_data[i] = 0; end
    for (int b = 0; b < NB; b++) begin m_ptr[b] = 0; m_ov[b] = 0; m_opr[b] = 0; m_odata[b] = 0; end
  endtask

  // Winner per bank: among slots holding a PR for that bank, the one at the
  // smallest forward distance from the bank's pointer.
  task automatic modelArbitrate();
    for (int b = 0; b < NB; b++) begin
      int best_dist;
      m_win[b]  = -1;
      best_dist = NW;
      for (int i = 0; i < NW; i++) begin
        if (m_bv[i] && (m_pr[i] % NB) == b && ((i - m_ptr[b] + NW) % NW) < best_dist) begin
          best_dist = (i - m_ptr[b] + NW) % NW;
          m_win[b]  = i;
        end
      end
    end
    for (int i = 0; i < NW; i++) begin
      m_ready[i] = !m_bv[i];
      for (int b = 0; b < NB; b++) if (m_win[b] == i) m_ready[i] = 1;
    end
  endtask

  task automatic modelAdvance();
    for (int b = 0; b < NB; b++) begin
      m_ov[b] = (m_win[b] >= 0);
      if (m_ov[b]) begin
        m_opr[b]   = m_pr[m_win[b]];
        m_odata[b] = m_data[m_win[b]];
        m_ptr[b]   = (m_win[b] + 1) % NW;
      end
    end
    for (int i = 0; i < NW; i++) begin
      if (wr_req_valid[i] && m_ready[i]) begin
        m_bv[i]   = (wr_req_PR[i] != 0);
        m_pr[i]   = int'(wr_req_PR[i]);
        m_data[i] = wr_req_data[i];
      end else if (m_ready[i]) begin
        m_bv[i] = 0;
      end
    end
  endtask

  // One clock cycle: the caller has set the request inputs; this drives
  // reset, checks ready before the edge, then checks the registered outputs.
  task automatic applyStimulus(input logic rst);
    @(negedge CLK);
    RST = rst;
    modelArbitrate();
    #1;
    for (int i = 0; i < NW; i++)
      checkOutput($sformatf("wr_req_ready[%0d]", i), 64'(wr_req_ready[i]), 64'(m_ready[i]));
    if (rst) modelReset();
    else     modelAdvance();
    @(posedge CLK);
    #1;
    for (int b = 0; b < NB; b++) begin
      checkOutput($sformatf("bank_wr_valid[%0d]", b), 64'(bank_wr_valid[b]), 64'(m_ov[b]));
      checkOutput($sformatf("wb_bus_valid[%0d]", b), 64'(wb_bus_valid[b]), 64'(m_ov[b]));
      if (m_ov[b]) begin
        checkOutput($sformatf("bank_wr_index[%0d]", b), 64'(bank_wr_index[b]), 64'(m_opr[b] / NB));
        checkOutput($sformatf("bank_wr_data[%0d]", b), 64'(bank_wr_data[b]), 64'(m_odata[b]));
        checkOutput($sformatf("wb_bus_PR[%0d]", b), 64'(wb_bus_PR[b]), 64'(m_opr[b]));
      end
    end
  endtask

  task automatic setIdle();
    wr_req_valid = '0;
    wr_req_PR    = '0;
    wr_req_data  = '0;
  endtask

  task automatic setReq(input int i, input int pr, input logic [31:0] data);
    wr_req_valid[i] = 1'b1;
    wr_req_PR[i]    = LPR'(pr);
    wr_req_data[i]  = data;
  endtask

  initial begin
    vector_count     = 0;
    miscompare_count = 0;
    RST = 1'b1;
    setIdle();
    repeat (2) @(posedge CLK);
    #1;
    modelReset();

    // Reset state
    applyStimulus(1'b1);
    checkOutput("reset bank_wr_valid", 64'(bank_wr_valid), 64'd0);
    checkOutput("reset bank_wr_index", 64'(bank_wr_index), 64'd0);
    checkOutput("reset bank_wr_data", 64'(bank_wr_data), 64'd0);
    checkOutput("reset wb_bus_PR", 64'(wb_bus_PR), 64'd0);
    checkOutput("reset wr_req_ready", 64'(wr_req_ready), 64'h7f);

    // Single write: requestor 2, PR 0x25, lands in bank 1 row 9 two cycles later
    setIdle(); setReq(2, 'h25, 32'hDEADBEEF);
    applyStimulus(1'b0);
    setIdle();
    applyStimulus(1'b0);
    checkOutput("single bank_wr_valid", 64'(bank_wr_valid), 64'b0010);
    checkOutput("single bank_wr_index", 64'(bank_wr_index[1]), 64'd9);
    checkOutput("single bank_wr_data", 64'(bank_wr_data[1]), 64'hDEADBEEF);
    checkOutput("single wb_bus_PR", 64'(wb_bus_PR[1]), 64'h25);
    applyStimulus(1'b0);

    // Bank conflict: three bank-0 entries drain in order 0, 3, 5
    setIdle(); setReq(0, 'h04, 32'hA0); setReq(3, 'h08, 32'hA3); setReq(5, 'h0C, 32'hA5);
    applyStimulus(1'b0);
    setIdle();
    repeat (4) applyStimulus(1'b0);

    // Fairness: requestors 0 and 1 keep offering bank-2 results
    for (int c = 0; c < 10; c++) begin
      setIdle();
      setReq(0, 'h02 + 4 * (c % 8), 32'h1000 + c);
      setReq(1, 'h06 + 4 * (c % 8), 32'h2000 + c);
      applyStimulus(1'b0);
    end
    setIdle();
    repeat (3) applyStimulus(1'b0);

    // Parallel banks: four different banks written in one cycle
    setIdle();
    for (int i = 0; i < 4; i++) setReq(i, 'h10 + i, 32'hB000 + i);
    applyStimulus(1'b0);
    setIdle();
    applyStimulus(1'b0);
    checkOutput("parallel bank_wr_valid", 64'(bank_wr_valid), 64'hf);
    checkOutput("parallel bank_wr_index", 64'(bank_wr_index), 64'({5'd4, 5'd4, 5'd4, 5'd4}));
    checkOutput("parallel bank_wr_data[3]", 64'(bank_wr_data[3]), 64'hB003);

    // PR 0 is accepted and dropped
    setIdle(); setReq(4, 0, 32'h1234);
    applyStimulus(1'b0);
    setIdle();
    repeat (3) applyStimulus(1'b0);

    // Reset with three contending bank-0 entries buffered
    setIdle(); setReq(1, 'h14, 32'hC1); setReq(2, 'h18, 32'hC2); setReq(6, 'h1C, 32'hC6);
    applyStimulus(1'b0);
    setIdle();
    applyStimulus(1'b1);
    checkOutput("midreset bank_wr_valid", 64'(bank_wr_valid), 64'd0);
    checkOutput("midreset wb_bus_valid", 64'(wb_bus_valid), 64'd0);
    checkOutput("midreset wb_bus_PR", 64'(wb_bus_PR), 64'd0);
    checkOutput("midreset wr_req_ready", 64'(wr_req_ready), 64'h7f);
    repeat (4) applyStimulus(1'b0);

    // Random traffic with occasional PR 0 and occasional reset
    for (int c = 0; c < 600; c++) begin
      setIdle();
      for (int i = 0; i < NW; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          setReq(i, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, NPR - 1)), $urandom);
        end
      end
      applyStimulus(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
    end
    setIdle();
    repeat (NW + 2) applyStimulus(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule

// File: doc/prf_write_arbiter.md
Name: prf_write_arbiter

Overview:
- Write-side counterpart of the PRF read-requestor arbitration. Collects writeback results from PRF_WR_COUNT functional-unit requestors and steers them into PRF_BANK_COUNT single-write-port banks.
- Each bank is selected by the low PR bits. Each requestor has a 1-entry buffer, and banks are arbitrated round-robin.
- Also drives a per-bank registered writeback broadcast that the IQs use for wakeup.

Parameters:
- XLEN, 32, data width
- PR_COUNT, 128, physical register count; LOG_PR_COUNT = $clog2(PR_COUNT)
- PRF_BANK_COUNT, 4, bank count; LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT)
- PRF_WR_COUNT, 7, write requestor count

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- wr_req_valid  in  [PRF_WR_COUNT]  requestor has a result
- wr_req_PR  in  [PRF_WR_COUNT][LOG_PR_COUNT]  destination PR
- wr_req_data  in  [PRF_WR_COUNT][XLEN]  result data
- wr_req_ready  out  [PRF_WR_COUNT]  buffer can accept this cycle
- bank_wr_valid  out  [PRF_BANK_COUNT]  bank write enable
- bank_wr_index  out  [PRF_BANK_COUNT][LOG_PR_COUNT-LOG_PRF_BANK_COUNT]  row within bank, equal to PR >> LOG_PRF_BANK_COUNT
- bank_wr_data  out  [PRF_BANK_COUNT][XLEN]  write data
- wb_bus_valid  out  [PRF_BANK_COUNT]  wakeup broadcast valid, identical to bank_wr_valid
- wb_bus_PR  out  [PRF_BANK_COUNT][LOG_PR_COUNT]  full PR being written

Behaviour:
- Handshake:
  - Transfer occurs when wr_req_valid[i] and wr_req_ready[i] are both high in the same cycle.
  - The requestor may drop valid at any time without penalty.
- Per-requestor buffer: buf_valid, buf_PR, buf_data.
  - wr_req_ready[i] = !buf_valid[i] | buf_grant[i]. This is combinational and allows a back-to-back refill in the cycle the entry drains.
  - On transfer the buffer loads next cycle.
  - The buffer clears when granted and no new transfer occurs.
- PR 0 handling:
  - A transfer with PR == 0 is accepted (ready per the rule above) but is never loaded. Any held entry is simply cleared.
  - PR 0 never appears on the bank or wakeup outputs.
- Bank target: bank b = buf_PR[LOG_PRF_BANK_COUNT-1:0].
- Arbitration, per bank, each cycle:
  - Candidates are buffered entries targeting the bank.
  - Grant the first candidate at or after rr_ptr[b], in increasing index order with wrap-around at PRF_WR_COUNT.
  - At most one grant per bank per cycle. Different banks grant independently, so up to PRF_BANK_COUNT grants per cycle.
  - A requestor targets only one bank, so it gets at most one grant.
- Round-robin pointer update:
  - On a grant in bank b, rr_ptr[b] <= granted index + 1, mod PRF_WR_COUNT.
  - rr_ptr[b] holds when bank b has no grant.
- Output timing:
  - bank_wr_*, wb_bus_* are registered. The grant in cycle t appears on the outputs in cycle t+1.
  - Request-to-write latency from an empty buffer is 2 cycles: accept at t, buffered and granted at t+1, write at t+2.
- Stall behaviour:
  - A losing buffered entry holds its PR and data unchanged and keeps ready low until granted.
  - Round-robin guarantees service within PRF_WR_COUNT-1 cycles of contention.
- Reset:
  - All buf_valid = 0, all rr_ptr = 0.
  - All bank_wr_valid and wb_bus_valid = 0; bank_wr_index, bank_wr_data and wb_bus_PR = 0.
  - wr_req_ready is high on the first cycle after reset.
  - Reset mid-operation discards all buffered entries and in-flight outputs. No write issues on the cycle after RST.
- Valid-low output cycles: index, data and PR hold their last values. The verifier checks them only when valid is high.

Test Plan:
- Single write: after reset, requestor 2 sends PR 0x25 (bank 1, index 9), data 0xDEADBEEF at cycle t.
  - Cycle t+2: bank_wr_valid = 0010, bank_wr_index[1] = 9, bank_wr_data[1] = 0xDEADBEEF, wb_bus_PR[1] = 0x25.
  - wr_req_ready[2] stays high throughout.
- Bank conflict: requestors 0, 3, 5 send PRs 0x04, 0x08, 0x0C (all bank 0) in the same cycle, rr_ptr[0] = 0.
  - Writes on consecutive cycles in order 0, 3, 5.
  - wr_req_ready[3] is low for 1 cycle and wr_req_ready[5] is low for 2 cycles; each held entry's data is unchanged when written.
- Fairness: requestors 0 and 1 continuously target bank 2 with new data every accepted cycle.
  - Bank 2 grants alternate 0, 1, 0, 1…; neither requestor waits more than 1 cycle.
- Parallel banks: requestors 0–3 send PRs 0x10, 0x11, 0x12, 0x13 in the same cycle.
  - All four bank_wr_valid are high in the same cycle, with indices 4, 4, 4, 4 and the correct data.
- PR 0 drop: requestor 4 sends PR 0 with data 0x1234.
  - wr_req_ready[4] is high; no bank_wr_valid or wb_bus_valid is ever asserted for it.
- Reset mid-op: three contending bank-0 entries are buffered; assert RST for 1 cycle.
  - All outputs are 0 in the cycle after RST; no pending writes ever appear; all wr_req_ready are high.
